activation_streamer: RTL and testbench
======================================

Name: activation_streamer

Overview:
- Source side of the accelerator's activation interface.
- Buffers one N x N 16-bit feature map written by the host controller.
- On start, streams the map in raster order onto activation with ce held high, then flushes the conv/pool pipeline.
- Watches the pooled-output side (valid_op/end_op), counts results, and reports done or timeout back to the host.

Parameters:
N, 10, feature-map side length (pixels per row/column)
K, 3, convolution kernel size (only used to derive EXP_OUT)
P, 2, pooling window (only used to derive EXP_OUT)
DW, 16, activation width
FLUSH, 2, extra ce-high cycles with activation=0 after the last pixel
TIMEOUT, 1024, max cycles to wait for end_op after flush

Ports:
clk  in  1  system clock
global_rst  in  1  synchronous active-high reset
wr_en  in  1  host write strobe into pixel buffer
wr_addr  in  clog2(N*N)  raster pixel index (row*N+col)
wr_data  in  DW  pixel value
start  in  1  single-cycle pulse: begin streaming
valid_op  in  1  pooled result strobe from accelerator
end_op  in  1  accelerator end-of-frame flag
ce  out  1  clock enable to convolver
activation  out  DW  pixel to convolver
busy  out  1  high from accepted start until done/timeout
done  out  1  one-cycle pulse: frame complete, out_count final
timeout  out  1  sticky: end_op not seen within TIMEOUT; cleared by next accepted start
wr_err  out  1  sticky: write attempted while busy (write dropped); cleared by next accepted start
out_count  out  16  valid_op pulses seen in current frame

Behaviour:
Reset (global_rst=1 at a clk edge):
- State IDLE; ce=0, activation=0, busy=0, done=0, timeout=0, wr_err=0, out_count=0, counters 0.
- Buffer contents are not cleared.
- Reset mid-frame aborts immediately; ce drops the cycle after reset is sampled.

Derived constant: EXP_OUT = ((N-K+1)/P)^2 (16 for defaults). Informational only; not enforced.

States:
- IDLE:
  - wr_en writes mem[wr_addr]; wr_addr >= N*N is ignored.
  - start accepted -> PREFETCH; clears timeout, wr_err, out_count; busy=1 next cycle.
  - start and wr_en in the same cycle: the write completes first.
- PREFETCH (1 cycle): synchronous buffer read of index 0 -> STREAM.
- STREAM: N*N cycles; in stream cycle i (0..N*N-1), ce=1 and activation=mem[i]. No gaps. After i=N*N-1 -> FLUSH, or WAIT_END if FLUSH=0.
- FLUSH: FLUSH cycles, ce=1, activation=0 -> WAIT_END.
- WAIT_END:
  - ce=0, activation=0; cycle counter increments.
  - end_op=1 -> DONE.
  - Counter reaches TIMEOUT -> set timeout -> IDLE (no done pulse).
- DONE (1 cycle): done=1, busy=0 -> IDLE.

Latency: start at cycle t -> first ce=1 with activation=mem[0] at t+2. busy deasserts in the DONE cycle.

Input handling rules:
- valid_op: counted in STREAM, FLUSH, WAIT_END and in the DONE-entering cycle. out_count saturates at 16'hFFFF. Ignored in IDLE.
- end_op during STREAM/FLUSH: recorded in a flag; WAIT_END exits on its first cycle.
- start while busy: ignored.
- wr_en while busy: dropped, sets wr_err.
- All outputs registered.

Decomposition:
- Shared package accel_pkg: state encoding (IDLE, PREFETCH, STREAM, FLUSH, WAIT_END, DONE), DW, and the clog2 helper / address-width function.
- Pixel store as sub-module act_buffer: single-port-write, single-port-read, synchronous-read RAM, N*N x DW, so it can map to BRAM.
- FSM and counters stay in activation_streamer.

Test Plan:
1. Load mem[i]=i for i=0..99 (N=10), pulse start at t -> ce high t+2..t+103 with activation 0..99 then 0,0 at t+102..t+103; model drives 16 valid_op pulses and end_op -> done pulses once, out_count=16, busy low.
2. Same frame; model never raises end_op -> timeout=1 exactly TIMEOUT cycles after WAIT_END entry, no done, FSM IDLE; next start clears timeout.
3. wr_en with wr_addr=5, data=16'hBEEF during STREAM -> wr_err=1, stream still outputs original mem[5]=5; write with wr_addr=100 in IDLE -> no buffer change, no error.
4. Assert global_rst at stream cycle 40 -> next cycle ce=0, busy=0, out_count=0; restart streams from mem[0] with the data from before reset.
5. end_op pulsed during FLUSH -> DONE reached one cycle after WAIT_END entry; start pulsed while busy -> no restart, activation sequence unbroken.
6. Same-cycle start and wr_en (addr 0, data 16'h1234) in IDLE -> first streamed pixel is 16'h1234.

Source files
------------

// File: rtl/accel_pkg.sv
`default_nettype none
//==============================================================================
// Module   : accel_pkg
// Brief    : Shared types and helpers for the activation source path.
// Revision : 1.0 - initial release
//==============================================================================
package accel_pkg;

    localparam int c_ACT_DW = 16;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREFETCH = 3'd1,
        S_STREAM   = 3'd2,
        S_FLUSH    = 3'd3,
        S_WAIT_END = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    function automatic int clog2_f(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    // Never returns zero so single-entry stores still get a 1-bit address.
    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : clog2_f(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/activation_streamer_if.sv
`default_nettype none
//==============================================================================
// Module   : activation_streamer_if
// Brief    : Host write/control and accelerator activation/result signals.
// Revision : 1.0 - initial release
//==============================================================================
interface activation_streamer_if
    import accel_pkg::*;
#(
    parameter int N  = 10,
    parameter int DW = c_ACT_DW
);
    localparam int c_AW = addr_width(N * N);

    logic            wr_en;
    logic [c_AW-1:0] wr_addr;
    logic [DW-1:0]   wr_data;
    logic            start;
    logic            valid_op;
    logic            end_op;
    logic            ce;
    logic [DW-1:0]   activation;
    logic            busy;
    logic            done;
    logic            timeout;
    logic            wr_err;
    logic [15:0]     out_count;

    modport slave (
        input  wr_en, wr_addr, wr_data, start, valid_op, end_op,
        output ce, activation, busy, done, timeout, wr_err, out_count
    );

    modport master (
        output wr_en, wr_addr, wr_data, start, valid_op, end_op,
        input  ce, activation, busy, done, timeout, wr_err, out_count
    );
endinterface
`default_nettype wire

// File: rtl/act_buffer.sv
`default_nettype none
//==============================================================================
// Module   : act_buffer
// Brief    : N*N x DW pixel store, one write port, one synchronous read port.
// Revision : 1.0 - initial release
//==============================================================================
module act_buffer
    import accel_pkg::*;
#(
    parameter int DEPTH = 100,
    parameter int DW    = c_ACT_DW,
    parameter int AW    = addr_width(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_wr_en,
    input  wire logic [AW-1:0] i_wr_addr,
    input  wire logic [DW-1:0] i_wr_data,
    input  wire logic          i_rd_en,
    input  wire logic [AW-1:0] i_rd_addr,
    output logic      [DW-1:0] o_rd_data
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Output register zeroes itself when not reading so it can drive the
    // activation bus directly between pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign o_rd_data = r_rd_data;
endmodule
`default_nettype wire

// File: rtl/activation_streamer.sv
`default_nettype none
//==============================================================================
// Module   : activation_streamer
// Brief    : Buffers one feature map, streams it to the convolver, flushes,
//            then waits for end-of-frame and reports done or timeout.
// Revision : 1.0 - initial release
//==============================================================================
module activation_streamer
    import accel_pkg::*;
#(
    parameter int N       = 10,
    parameter int K       = 3,
    parameter int P       = 2,
    parameter int DW      = c_ACT_DW,
    parameter int FLUSH   = 2,
    parameter int TIMEOUT = 1024
) (
    input  wire logic            clk,
    input  wire logic            global_rst,
    activation_streamer_if.slave bus
);
    localparam int c_DEPTH    = N * N;
    localparam int c_AW       = addr_width(c_DEPTH);
    localparam int c_AWX      = c_AW + 1;
    localparam int c_EXP_OUT  = ((N - K + 1) / P) * ((N - K + 1) / P);
    localparam int c_SPAN     = (c_DEPTH > TIMEOUT) ? ((c_DEPTH > FLUSH) ? c_DEPTH : FLUSH)
                                                    : ((TIMEOUT > FLUSH) ? TIMEOUT : FLUSH);
    localparam int c_CW       = addr_width(c_SPAN + 1);

    localparam logic [c_CW-1:0]  c_LAST_PIX   = c_CW'(c_DEPTH - 1);
    localparam logic [c_CW-1:0]  c_LAST_FLUSH = c_CW'((FLUSH > 0) ? FLUSH - 1 : 0);
    localparam logic [c_CW-1:0]  c_LAST_WAIT  = c_CW'(TIMEOUT - 1);
    localparam logic [c_AWX-1:0] c_DEPTH_V    = c_AWX'(c_DEPTH);

    if (c_EXP_OUT < 1 || FLUSH < 0 || TIMEOUT < 1) begin : g_cfg_check
        $error("activation_streamer: unsupported parameter set");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_CW-1:0]   r_cnt;
    logic [c_CW-1:0]   w_cnt_nxt;
    logic [c_CW-1:0]   w_cnt_inc;
    logic              w_timeout_hit;
    logic              w_idle;
    logic              w_start_ok;
    logic              w_wr_ok;
    logic              w_counting;
    logic              w_rd_en;
    logic [c_AW-1:0]   w_rd_addr;
    logic [DW-1:0]     w_rd_data;

    logic              r_ce;
    logic              r_busy;
    logic              r_done;
    logic              r_timeout;
    logic              r_wr_err;
    logic              r_end_seen;
    logic [15:0]       r_out_count;

    assign w_idle     = (r_state == S_IDLE);
    assign w_start_ok = w_idle && bus.start;
    assign w_wr_ok    = w_idle && bus.wr_en && ({1'b0, bus.wr_addr} < c_DEPTH_V);
    assign w_counting = (r_state == S_STREAM) || (r_state == S_FLUSH) || (r_state == S_WAIT_END);
    assign w_cnt_inc  = r_cnt + 1'b1;

    // Read one pixel ahead: PREFETCH fetches pixel 0, stream cycle i fetches i+1.
    assign w_rd_en   = (r_state == S_PREFETCH) || ((r_state == S_STREAM) && (r_cnt != c_LAST_PIX));
    assign w_rd_addr = (r_state == S_STREAM) ? w_cnt_inc[c_AW-1:0] : '0;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = S_PREFETCH;
            end
            S_PREFETCH: begin
                w_state_nxt = S_STREAM;
                w_cnt_nxt   = '0;
            end
            S_STREAM: begin
                if (r_cnt == c_LAST_PIX) begin
                    w_state_nxt = (FLUSH > 0) ? S_FLUSH : S_WAIT_END;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_FLUSH: begin
                if (r_cnt == c_LAST_FLUSH) begin
                    w_state_nxt = S_WAIT_END;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_WAIT_END: begin
                if (bus.end_op || r_end_seen) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_LAST_WAIT) begin
                    w_state_nxt   = S_IDLE;
                    w_cnt_nxt     = '0;
                    w_timeout_hit = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (global_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (global_rst) begin
            r_ce        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_wr_err    <= 1'b0;
            r_end_seen  <= 1'b0;
            r_out_count <= '0;
        end else begin
            r_ce   <= (w_state_nxt == S_STREAM) || (w_state_nxt == S_FLUSH);
            r_busy <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            r_done <= (w_state_nxt == S_DONE);
            if (w_start_ok) begin
                r_timeout   <= 1'b0;
                r_wr_err    <= 1'b0;
                r_end_seen  <= 1'b0;
                r_out_count <= '0;
            end else begin
                if (w_timeout_hit) r_timeout <= 1'b1;
                if (bus.wr_en && !w_idle) r_wr_err <= 1'b1;
                if (w_counting && bus.valid_op && (r_out_count != 16'hFFFF)) begin
                    r_out_count <= r_out_count + 16'd1;
                end
                // Early end-of-frame lets WAIT_END finish on its first cycle.
                if (((r_state == S_STREAM) || (r_state == S_FLUSH)) && bus.end_op) begin
                    r_end_seen <= 1'b1;
                end
            end
        end
    end

    act_buffer #(
        .DEPTH (c_DEPTH),
        .DW    (DW),
        .AW    (c_AW)
    ) u_act_buffer (
        .clk       (clk),
        .rst       (global_rst),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (bus.wr_addr),
        .i_wr_data (bus.wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign bus.ce         = r_ce;
    assign bus.activation = w_rd_data;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.timeout    = r_timeout;
    assign bus.wr_err     = r_wr_err;
    assign bus.out_count  = r_out_count;
endmodule
`default_nettype wire

// File: tb/tb_activation_streamer.sv
`default_nettype none
//==============================================================================
// Module   : tb_activation_streamer
// Brief    : Self-checking bench: frame-timeline model plus literal spot checks.
// Revision : 1.0 - initial release
//==============================================================================
module tb_activation_streamer;
    localparam int N         = 10;
    localparam int NN        = N * N;
    localparam int FLUSH_C   = 2;
    localparam int TIMEOUT_C = 1024;
    localparam int W         = 2 + NN + FLUSH_C;   // offset of first WAIT_END cycle

    logic clk = 1'b0;
    logic global_rst = 1'b1;

    activation_streamer_if #(.N(N), .DW(16)) bus ();

    activation_streamer #(
        .N(N), .K(3), .P(2), .DW(16), .FLUSH(FLUSH_C), .TIMEOUT(TIMEOUT_C)
    ) dut (
        .clk        (clk),
        .global_rst (global_rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame model: a frame is a timeline of offsets j from the start cycle.
    int  mem_m [NN];
    bit  m_ready = 1'b0, m_active = 1'b0, m_to = 1'b0, m_err = 1'b0, m_endflag = 1'b0;
    int  m_j = 0, m_done_at = -1, m_cnt = 0;
    bit  e_ce = 1'b0, e_busy = 1'b0, e_done = 1'b0;
    int  e_act = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (global_rst) begin
                m_ready = 1'b1; m_active = 1'b0; m_to = 1'b0; m_err = 1'b0;
                m_cnt = 0; m_endflag = 1'b0; m_done_at = -1; m_j = 0;
            end else if (!m_active) begin
                if (bus.wr_en && int'(bus.wr_addr) < NN) mem_m[bus.wr_addr] = int'(bus.wr_data);
                if (bus.start) begin
                    m_active = 1'b1; m_j = 1; m_to = 1'b0; m_err = 1'b0;
                    m_cnt = 0; m_endflag = 1'b0; m_done_at = -1;
                end
            end else begin
                if (bus.wr_en) m_err = 1'b1;
                if (m_j >= 2 && m_j != m_done_at && bus.valid_op && m_cnt < 65535) m_cnt++;
                if (m_j == m_done_at) begin
                    m_active = 1'b0;
                end else if (m_j >= W) begin
                    if (bus.end_op || m_endflag) m_done_at = m_j + 1;
                    else if (m_j == W + TIMEOUT_C - 1) begin
                        m_to = 1'b1; m_active = 1'b0;
                    end
                end else if (m_j >= 2 && bus.end_op) begin
                    m_endflag = 1'b1;
                end
                m_j++;
            end
            e_ce   = m_active && m_j >= 2 && m_j < W;
            e_act  = (m_active && m_j >= 2 && m_j < 2 + NN) ? mem_m[m_j - 2] : 0;
            e_busy = m_active && m_j != m_done_at;
            e_done = m_active && m_j == m_done_at;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_ready) begin
                chk("ce",         {31'd0, bus.ce},         {31'd0, e_ce});
                chk("activation", {16'd0, bus.activation}, e_act);
                chk("busy",       {31'd0, bus.busy},       {31'd0, e_busy});
                chk("done",       {31'd0, bus.done},       {31'd0, e_done});
                chk("timeout",    {31'd0, bus.timeout},    {31'd0, m_to});
                chk("wr_err",     {31'd0, bus.wr_err},     {31'd0, m_err});
                chk("out_count",  {16'd0, bus.out_count},  m_cnt);
                if (bus.done === 1'b1) done_pulses++;
            end
        end
    end

    // Hand-computed spot expectations, keyed by frame offset.
    typedef struct { int j; int sig; int val; } lit_t;
    lit_t lits[$];

    task automatic add_lit(input int j, input int sig, input int val);
        lit_t l;
        l.j = j; l.sig = sig; l.val = val;
        lits.push_back(l);
    endtask

    task automatic check_lits(input int j);
        logic [31:0] v;
        string nm;
        foreach (lits[i]) begin
            if (lits[i].j == j) begin
                case (lits[i].sig)
                    0: begin v = {31'd0, bus.ce};         nm = "lit_ce";        end
                    1: begin v = {16'd0, bus.activation}; nm = "lit_act";       end
                    2: begin v = {31'd0, bus.busy};       nm = "lit_busy";      end
                    3: begin v = {31'd0, bus.done};       nm = "lit_done";      end
                    4: begin v = {31'd0, bus.timeout};    nm = "lit_timeout";   end
                    5: begin v = {31'd0, bus.wr_err};     nm = "lit_wr_err";    end
                    default: begin v = {16'd0, bus.out_count}; nm = "lit_out_count"; end
                endcase
                chk($sformatf("%s@j%0d", nm, j), v, lits[i].val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.valid_op = 1'b0; bus.end_op = 1'b0;
        global_rst = 1'b0;
    endtask

    // vpct < 0: exactly 16 valid_op pulses at j = 10 + 6m.
    task automatic run_frame(input int end_j, input int vpct, input int wr_j, input int wr_addr,
                             input int wr_data, input int start_j, input int rst_j,
                             input bit swr, input int swr_data);
        int len;
        if (rst_j >= 0)       len = rst_j + 2;
        else if (end_j < 0)   len = W + TIMEOUT_C + 3;
        else if (end_j < W)   len = W + 4;
        else                  len = end_j + 4;
        bus.start = 1'b1;
        if (swr) begin
            bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = swr_data[15:0];
        end
        step();
        clear_inputs();
        for (int j = 1; j <= len; j++) begin
            if (vpct < 0) bus.valid_op = (j >= 10 && j < 106 && (j - 10) % 6 == 0);
            else          bus.valid_op = ($urandom_range(0, 99) < vpct);
            bus.end_op = (j == end_j);
            bus.wr_en  = (j == wr_j);
            bus.wr_addr = 7'(wr_addr);
            bus.wr_data = wr_data[15:0];
            bus.start  = (j == start_j);
            global_rst = (j == rst_j);
            @(negedge clk);
            check_lits(j);
            step();
        end
        clear_inputs();
        lits.delete();
        step();
    endtask

    initial begin
        int dp0;
        clear_inputs();
        global_rst = 1'b1;
        repeat (3) step();
        global_rst = 1'b0;
        step();

        // Load mem[i] = i, then an out-of-range write that must be ignored.
        for (int i = 0; i < NN; i++) begin
            bus.wr_en = 1'b1; bus.wr_addr = 7'(i); bus.wr_data = 16'(i);
            step();
        end
        bus.wr_addr = 7'd100; bus.wr_data = 16'hDEAD;
        step();
        clear_inputs();
        @(negedge clk);
        chk("idle_oob_wr_err", {31'd0, bus.wr_err}, 32'd0);
        step();

        // Basic frame with 16 results and end_op in WAIT_END.
        add_lit(1, 2, 1);   add_lit(1, 0, 0);
        add_lit(2, 0, 1);   add_lit(2, 1, 0);
        add_lit(45, 1, 43); add_lit(101, 1, 99);
        add_lit(102, 0, 1); add_lit(102, 1, 0); add_lit(103, 0, 1);
        add_lit(104, 0, 0);
        add_lit(107, 3, 1); add_lit(107, 2, 0); add_lit(107, 6, 16);
        add_lit(108, 3, 0);
        dp0 = done_pulses;
        run_frame(W + 2, -1, -1, 0, 0, -1, -1, 1'b0, 0);
        chk("frame1_done_pulses", done_pulses - dp0, 32'd1);

        // No end_op: timeout exactly TIMEOUT cycles after WAIT_END entry.
        add_lit(W + TIMEOUT_C - 1, 4, 0); add_lit(W + TIMEOUT_C - 1, 2, 1);
        add_lit(W + TIMEOUT_C, 4, 1);     add_lit(W + TIMEOUT_C, 2, 0);
        add_lit(W + TIMEOUT_C, 3, 0);
        dp0 = done_pulses;
        run_frame(-1, 10, -1, 0, 0, -1, -1, 1'b0, 0);
        chk("timeout_done_pulses", done_pulses - dp0, 32'd0);
        add_lit(1, 4, 0); add_lit(1, 2, 1);
        add_lit(W, 3, 0); add_lit(W + 1, 3, 1);
        run_frame(50, 20, -1, 0, 0, -1, -1, 1'b0, 0);

        // Write during STREAM is dropped and flagged.
        add_lit(3, 5, 0); add_lit(4, 5, 1); add_lit(7, 1, 5);
        run_frame(W, 15, 3, 5, 16'hBEEF, -1, -1, 1'b0, 0);

        // Reset at stream cycle 40, then restart from the retained buffer.
        add_lit(42, 0, 1); add_lit(42, 1, 40);
        add_lit(43, 0, 0); add_lit(43, 2, 0); add_lit(43, 6, 0); add_lit(43, 1, 0);
        run_frame(-1, 40, -1, 0, 0, -1, 42, 1'b0, 0);
        add_lit(2, 1, 0); add_lit(3, 1, 1);
        run_frame(60, 25, -1, 0, 0, -1, -1, 1'b0, 0);

        // end_op during FLUSH and a start while busy.
        add_lit(21, 1, 19); add_lit(22, 1, 20);
        add_lit(W, 3, 0); add_lit(W, 2, 1); add_lit(W + 1, 3, 1);
        run_frame(W - 1, 30, -1, 0, 0, 20, -1, 1'b0, 0);

        // Same-cycle start and write to address 0.
        add_lit(2, 1, 16'h1234); add_lit(3, 1, 1);
        run_frame(W + 10, 20, -1, 0, 0, -1, -1, 1'b1, 16'h1234);

        // Randomized frames.
        for (int r = 0; r < 6; r++) begin
            int nw;
            nw = $urandom_range(0, 12);
            for (int k = 0; k < nw; k++) begin
                bus.wr_en = 1'b1;
                bus.wr_addr = 7'($urandom_range(0, 127));
                bus.wr_data = 16'($urandom_range(0, 65535));
                step();
            end
            clear_inputs();
            step();
            run_frame($urandom_range(2, W + 300), $urandom_range(0, 60),
                      ($urandom_range(0, 1) == 1) ? $urandom_range(1, W) : -1,
                      $urandom_range(0, 127), $urandom_range(0, 65535),
                      ($urandom_range(0, 1) == 1) ? $urandom_range(1, W) : -1, -1,
                      ($urandom_range(0, 3) == 0), $urandom_range(0, 65535));
        end

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
